// File: rtl/sha_share_checker_if.sv
// Bundle between the double-hash core, the result checker and the host.
// Core side: result stream. Host side: winning-nonce valid/ready queue plus status.
interface sha_share_checker_if;
  logic         input_valid;
  logic         newblock_i;
  logic [255:0] doublehash;
  logic [255:0] target;
  logic         found_valid;
  logic         found_ready;
  logic [31:0]  found_nonce;
  logic [7:0]   found_block;
  logic         overflow;
  logic [31:0]  hash_count;

  modport master (
    output input_valid, newblock_i, doublehash, target, found_ready,
    input  found_valid, found_nonce, found_block, overflow, hash_count
  );

  modport slave (
    input  input_valid, newblock_i, doublehash, target, found_ready,
    output found_valid, found_nonce, found_block, overflow, hash_count
  );
endinterface

// File: rtl/sha_share_checker.sv
// Checks each finished double hash against the difficulty target, recovers its
// nonce by counting results since the last new-block marker and queues hits.
module sha_share_checker #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  sha_share_checker_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Bitcoin compares the hash as a little-endian number: byte 0 of a is the LSB.
  function automatic logic [255:0] byte_rev(input logic [255:0] h);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) begin
      v[8*k +: 8] = h[255 - 8*k -: 8];
    end
    return v;
  endfunction

  logic [31:0]  r_nonce_cnt;
  logic [7:0]   r_blk_id;
  logic [31:0]  r_hash_cnt;
  logic [31:0]  w_nonce;
  logic [7:0]   w_blk;

  logic         r_vld_p1;
  logic [255:0] r_hv_p1;
  logic [255:0] r_tgt_p1;
  logic [31:0]  r_nonce_p1;
  logic [7:0]   r_blk_p1;

  logic [39:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_hit;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [39:0]   w_head;

  // Stage 0: nonce and block id recovery from the result stream
  always_comb begin
    w_nonce = bus.newblock_i ? 32'd0 : r_nonce_cnt;
    w_blk   = bus.newblock_i ? r_blk_id + 8'd1 : r_blk_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nonce_cnt <= '0;
      r_blk_id    <= '0;
      r_hash_cnt  <= '0;
    end else if (bus.input_valid) begin
      r_nonce_cnt <= bus.newblock_i ? 32'd1 : r_nonce_cnt + 32'd1;
      r_blk_id    <= w_blk;
      r_hash_cnt  <= r_hash_cnt + 32'd1;
    end
  end

  // Stage 1: registered value, target and tags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= bus.input_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.input_valid) begin
      r_hv_p1    <= byte_rev(bus.doublehash);
      r_tgt_p1   <= bus.target;
      r_nonce_p1 <= w_nonce;
      r_blk_p1   <= w_blk;
    end
  end

  // Stage 2: compare and push into the FWFT queue
  always_comb begin
    w_hit   = r_vld_p1 && (r_hv_p1 <= r_tgt_p1);
    w_empty = (r_count == '0);
    w_full  = (r_count == FULL_CNT);
    w_pop   = !w_empty && bus.found_ready;
    w_push  = w_hit && (!w_full || w_pop);
    w_drop  = w_hit && w_full && !w_pop;
    w_head  = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_nonce_p1, r_blk_p1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.found_valid = !w_empty;
  assign bus.found_nonce = w_empty ? 32'd0 : w_head[39:8];
  assign bus.found_block = w_empty ? 8'd0 : w_head[7:0];
  assign bus.overflow    = r_overflow;
  assign bus.hash_count  = r_hash_cnt;

endmodule

// File: tb/tb_sha_share_checker.sv
// Bench for sha_share_checker: cycle scoreboard of the hit queue plus directed
// checks on latency, byte order, nonce recovery, overflow, drain and reset.
module tb_sha_share_checker;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha_share_checker_if bus();

  sha_share_checker #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value of a hash: shift bytes in from h[7:0] upward, so h[7:0] ends as MSB.
  function automatic logic [255:0] ref_value(input logic [255:0] h);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v = {v[247:0], h[8*i +: 8]};
    return v;
  endfunction

  typedef struct packed {
    logic        vld;
    logic        hit;
    logic [31:0] nonce;
    logic [7:0]  blk;
  } s1_t;

  logic [39:0] sb[$];
  logic [39:0] got_q[$];
  s1_t         m_s1;
  logic [31:0] m_cnt;
  logic [31:0] m_hash;
  logic [7:0]  m_blk;
  logic        m_ovf;
  bit          armed = 1'b0;

  // Scoreboard: compare outputs of the current cycle, then apply this edge's pop/push.
  always @(negedge clk) begin
    if (armed) begin
      check_eq("found_valid", bus.found_valid, sb.size() != 0);
      check_eq("hash_count", bus.hash_count, m_hash);
      check_eq("overflow", bus.overflow, m_ovf);
      if (sb.size() != 0) check_eq("head", {bus.found_nonce, bus.found_block}, sb[0]);
      else                check_eq("empty_head", {bus.found_nonce, bus.found_block}, 64'd0);
    end
    if (rst) begin
      sb.delete();
      m_s1   = '0;
      m_cnt  = '0;
      m_hash = '0;
      m_blk  = '0;
      m_ovf  = 1'b0;
      armed  = 1'b1;
    end else begin
      if (sb.size() != 0 && bus.found_ready) begin
        got_q.push_back({bus.found_nonce, bus.found_block});
        void'(sb.pop_front());
      end
      if (m_s1.vld && m_s1.hit) begin
        if (sb.size() < DEPTH) sb.push_back({m_s1.nonce, m_s1.blk});
        else                   m_ovf = 1'b1;
      end
      m_s1 = '0;
      if (bus.input_valid) begin
        m_hash    = m_hash + 32'd1;
        m_s1.vld  = 1'b1;
        m_s1.hit  = ref_value(bus.doublehash) <= bus.target;
        if (bus.newblock_i) begin
          m_blk      = m_blk + 8'd1;
          m_s1.nonce = 32'd0;
          m_cnt      = 32'd1;
        end else begin
          m_s1.nonce = m_cnt;
          m_cnt      = m_cnt + 32'd1;
        end
        m_s1.blk = m_blk;
      end
    end
  end

  logic [255:0] HIT_H, MISS_H, T255, H1, BO_H, EQ_H, BO_V;

  task automatic drive(input logic v, input logic nb, input logic [255:0] h, input logic [255:0] t);
    @(posedge clk); #1;
    bus.input_valid = v;
    bus.newblock_i  = nb;
    bus.doublehash  = h;
    bus.target      = t;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, T255);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.input_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
  endtask

  initial begin
    HIT_H  = '0;
    MISS_H = '1;
    T255   = {1'b1, 255'b0};
    H1     = {{7{32'hDEADBEEF}}, 32'h0};
    BO_H   = {32'h000000FF, {7{32'hFFFFFFFF}}};
    EQ_H   = {32'hFF000000, 224'h0};
    BO_V   = {{29{8'hFF}}, 24'h0};
    bus.input_valid = 1'b0;
    bus.newblock_i  = 1'b0;
    bus.doublehash  = '0;
    bus.target      = '0;
    bus.found_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_valid", bus.found_valid, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    check_eq("rst_count", bus.hash_count, 0);
    check_eq("rst_nonce", bus.found_nonce, 0);
    check_eq("rst_block", bus.found_block, 0);

    // Hit on the first hash: visible two cycles later
    drive(1'b1, 1'b1, H1, T255);
    idle(1);
    check_eq("t1_valid_n1", bus.found_valid, 0);
    idle(1);
    check_eq("t1_valid_n2", bus.found_valid, 1);
    check_eq("t1_nonce", bus.found_nonce, 0);
    check_eq("t1_block", bus.found_block, 1);
    check_eq("t1_count", bus.hash_count, 1);
    idle(2);

    // Byte order and equality
    do_reset();
    drive(1'b1, 1'b1, BO_H, 256'hFF);
    drive(1'b1, 1'b0, EQ_H, 256'hFF);
    drive(1'b1, 1'b0, EQ_H, 256'hFE);
    drive(1'b1, 1'b0, BO_H, BO_V);
    idle(4);
    check_eq("bo_hits", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("bo_eq_small", got_q[0], {32'd1, 8'd1});
      check_eq("bo_eq_big", got_q[1], {32'd3, 8'd1});
    end

    // Nonce recovery across two blocks
    do_reset();
    for (int i = 0; i < 9; i++)
      drive(1'b1, i == 0, (i == 5 || i == 8) ? HIT_H : MISS_H, T255);
    drive(1'b1, 1'b1, HIT_H, T255);
    idle(4);
    check_eq("nr_hits", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check_eq("nr_first", got_q[0], {32'd5, 8'd1});
      check_eq("nr_second", got_q[1], {32'd8, 8'd1});
      check_eq("nr_newblock", got_q[2], {32'd0, 8'd2});
    end

    // Overflow, then push and pop together while full
    do_reset();
    bus.found_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, i == 0, HIT_H, T255);
    idle(3);
    check_eq("ov_flag", bus.overflow, 1);
    check_eq("ov_head", bus.found_nonce, 0);
    drive(1'b1, 1'b0, HIT_H, T255);
    @(posedge clk); #1;
    bus.input_valid = 1'b0;
    bus.found_ready = 1'b1;
    @(posedge clk); #1;
    bus.found_ready = 1'b0;
    check_eq("ov_pp_head", bus.found_nonce, 1);
    idle(2);
    bus.found_ready = 1'b1;
    idle(8);
    check_eq("ov_drained", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check_eq("ov_e0", got_q[0], {32'd0, 8'd1});
      check_eq("ov_e1", got_q[1], {32'd1, 8'd1});
      check_eq("ov_e2", got_q[2], {32'd2, 8'd1});
      check_eq("ov_e3", got_q[3], {32'd3, 8'd1});
      check_eq("ov_e4", got_q[4], {32'd6, 8'd1});
    end
    check_eq("ov_sticky", bus.overflow, 1);

    // Back-to-back drain
    do_reset();
    check_eq("dr_ovf_cleared", bus.overflow, 0);
    bus.found_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, HIT_H, T255);
    idle(3);
    bus.found_ready = 1'b1;
    check_eq("dr_v0", bus.found_valid, 1);
    @(posedge clk); #1;
    check_eq("dr_v1", bus.found_valid, 1);
    @(posedge clk); #1;
    check_eq("dr_v2", bus.found_valid, 1);
    @(posedge clk); #1;
    check_eq("dr_v3", bus.found_valid, 0);
    check_eq("dr_count", got_q.size(), 3);
    if (got_q.size() == 3) check_eq("dr_last", got_q[2], {32'd2, 8'd1});

    // Reset with a hit in stage 1 and two entries queued
    do_reset();
    bus.found_ready = 1'b0;
    drive(1'b1, 1'b1, HIT_H, T255);
    drive(1'b1, 1'b0, HIT_H, T255);
    idle(2);
    drive(1'b1, 1'b0, HIT_H, T255);
    @(posedge clk); #1;
    bus.input_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rm_valid", bus.found_valid, 0);
    check_eq("rm_count", bus.hash_count, 0);
    check_eq("rm_overflow", bus.overflow, 0);
    @(posedge clk); #1;
    check_eq("rm_valid_next", bus.found_valid, 0);
    got_q.delete();
    bus.found_ready = 1'b1;
    drive(1'b1, 1'b1, HIT_H, T255);
    idle(4);
    check_eq("rm_hits", got_q.size(), 1);
    if (got_q.size() == 1) check_eq("rm_entry", got_q[0], {32'd0, 8'd1});

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
